// File: rtl/kronecker_zero_map_d2.sv
// kronecker_zero_map_d2
// Back-end of the second-order masked Kronecker-delta tree. The incoming
// 3-share byte x is delayed to meet the tree's 3-share delta output. Delta is
// then folded into bit 0 of each share, so that x' = x ^ delta(x) and a zero
// byte maps to 1. The delta shares are re-timed again so that the inversion
// path can undo the mapping later.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   in_valid        shared_inp carries a new byte this cycle
//   shared_inp      share j bit i at [8j+i]
//   delta_sh        delta share j at bit j, aligned KRON_LAT cycles after in_valid
//   out_valid       out_shares carries a mapped byte
//   out_shares      mapped shares, same layout as shared_inp
//   delta_dly_valid delta_dly carries delta shares
//   delta_dly       delta shares, UNMAP_LAT cycles after out_valid
//   in_flight       bytes accepted and not yet retired on delta_dly_valid
//   busy            in_flight != 0
module kronecker_zero_map_d2 #(
   parameter int unsigned KRON_LAT  = 3,
   parameter int unsigned UNMAP_LAT = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [23:0]      shared_inp,
   input  logic [2:0]       delta_sh,
   output logic             out_valid,
   output logic [23:0]      out_shares,
   output logic             delta_dly_valid,
   output logic [2:0]       delta_dly,
   output logic [CNT_W-1:0] in_flight,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // share delay line, stage k holds the byte sampled k cycles ago
   logic [KRON_LAT:1]  sv_q;
   logic [23:0]        sd_q [1:KRON_LAT];

   logic               out_valid_q;
   logic [23:0]        out_sh_q;
   logic [23:0]        out_map_d;

   // delta delay line, stage 0 is loaded together with out_valid
   logic [UNMAP_LAT:1] dv_q;
   logic [2:0]         dd_q [0:UNMAP_LAT];

   logic [CNT_W-1:0]   in_flight_q;
   logic [CNT_W-1:0]   in_flight_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sv_q[1]  <= 1'b0;
         sd_q[1]  <= '0;
      end else begin
         sv_q[1] <= in_valid;
         if (in_valid) sd_q[1] <= shared_inp;
      end
   end

   for (genvar k = 2; k <= KRON_LAT; k++) begin : g_sh_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sv_q[k] <= 1'b0;
            sd_q[k] <= '0;
         end else begin
            sv_q[k] <= sv_q[k-1];
            if (sv_q[k-1]) sd_q[k] <= sd_q[k-1];
         end
      end
   end

   // Each delta share only touches bit 0 of its own share; no share mixing.
   assign out_map_d = sd_q[KRON_LAT] ^ {7'd0, delta_sh[2], 7'd0, delta_sh[1], 7'd0, delta_sh[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sh_q    <= '0;
         dd_q[0]     <= '0;
      end else begin
         out_valid_q <= sv_q[KRON_LAT];
         if (sv_q[KRON_LAT]) begin
            out_sh_q <= out_map_d;
            dd_q[0]  <= delta_sh;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q[1] <= 1'b0;
         dd_q[1] <= '0;
      end else begin
         dv_q[1] <= out_valid_q;
         if (out_valid_q) dd_q[1] <= dd_q[0];
      end
   end

   for (genvar k = 2; k <= UNMAP_LAT; k++) begin : g_dd_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dv_q[k] <= 1'b0;
            dd_q[k] <= '0;
         end else begin
            dv_q[k] <= dv_q[k-1];
            if (dv_q[k-1]) dd_q[k] <= dd_q[k-1];
         end
      end
   end

   always_comb begin
      in_flight_d = in_flight_q;
      if (in_valid && !dv_q[UNMAP_LAT]) begin
         in_flight_d = in_flight_q + CNT_ONE;
      end else if (!in_valid && dv_q[UNMAP_LAT]) begin
         in_flight_d = in_flight_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_flight_q <= '0;
      else        in_flight_q <= in_flight_d;
   end

   // CNT_W is sized so these never fire; they catch a mis-parameterisation.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(in_valid && !dv_q[UNMAP_LAT] && (in_flight_q == '1)));
         assert (!(!in_valid && dv_q[UNMAP_LAT] && (in_flight_q == '0)));
      end
   end

   assign out_valid       = out_valid_q;
   assign out_shares      = out_sh_q;
   assign delta_dly_valid = dv_q[UNMAP_LAT];
   assign delta_dly       = dd_q[UNMAP_LAT];
   assign in_flight       = in_flight_q;
   assign busy            = (in_flight_q != '0);

endmodule

// File: tb/tb_kronecker_zero_map_d2.sv
// Testbench for kronecker_zero_map_d2: directed scenarios followed by a long
// randomised run checked against a cycle-indexed history model.
module tb_kronecker_zero_map_d2;

   localparam int CNT_W = 4;
   localparam int NC    = 14000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic [23:0]      shared_inp = '0;
   logic [2:0]       delta_sh = '0;
   logic             out_valid;
   logic [23:0]      out_shares;
   logic             delta_dly_valid;
   logic [2:0]       delta_dly;
   logic [CNT_W-1:0] in_flight;
   logic             busy;

   int n_chk = 0;
   int n_fail = 0;

   // history of the randomised run, indexed by cycle
   logic        vh  [NC];
   logic [7:0]  xh  [NC];
   logic [23:0] shh [NC];
   logic [2:0]  dh  [NC];

   kronecker_zero_map_d2 #(.KRON_LAT(3), .UNMAP_LAT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .shared_inp(shared_inp),
      .delta_sh(delta_sh), .out_valid(out_valid), .out_shares(out_shares),
      .delta_dly_valid(delta_dly_valid), .delta_dly(delta_dly),
      .in_flight(in_flight), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] recomb(input logic [23:0] s);
      return s[7:0] ^ s[15:8] ^ s[23:16];
   endfunction

   function automatic logic [7:0] mapped(input logic [7:0] x);
      return (x == 8'h00) ? 8'h01 : x;
   endfunction

   function automatic logic [23:0] mk_shares(input logic [7:0] x);
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      return {x ^ a ^ b, b, a};
   endfunction

   function automatic logic [2:0] mk_delta(input logic d);
      logic [1:0] r;
      r = 2'($urandom);
      return {d ^ r[1] ^ r[0], r};
   endfunction

   // expected shares: bit 0 of share j flipped by delta share j
   function automatic logic [23:0] apply_delta(input logic [23:0] s, input logic [2:0] d);
      logic [23:0] r;
      r = s;
      r[0]  = s[0]  ^ d[0];
      r[8]  = s[8]  ^ d[1];
      r[16] = s[16] ^ d[2];
      return r;
   endfunction

   task automatic next_cycle(input logic v, input logic [23:0] sh, input logic [2:0] d);
      @(negedge clk);
      in_valid   = v;
      shared_inp = sh;
      delta_sh   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle(1'b0, 24'h0, 3'b000);
   endtask

   task automatic test_reset();
      logic [23:0] s;
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b want 0", out_valid); end
      n_chk++; if (out_shares !== 24'h0) begin n_fail++; $display("FAIL rst_os: got %h want 000000", out_shares); end
      n_chk++; if (delta_dly_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b want 0", delta_dly_valid); end
      n_chk++; if (delta_dly !== 3'b000) begin n_fail++; $display("FAIL rst_dd: got %b want 000", delta_dly); end
      n_chk++; if (in_flight !== 4'd0) begin n_fail++; $display("FAIL rst_if: got %0d want 0", in_flight); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      repeat (2) @(negedge clk);
      // byte presented in the first cycle after release
      s = mk_shares(8'hA5);
      rst_n = 1'b1; in_valid = 1'b1; shared_inp = s; delta_sh = 3'b000;
      next_cycle(1'b0, 24'h0, 3'b000);
      next_cycle(1'b0, 24'h0, 3'b000);
      next_cycle(1'b0, 24'h0, mk_delta(1'b0));
      next_cycle(1'b0, 24'h0, 3'b000);
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_ov: got %b want 1", out_valid); end
      n_chk++; if (recomb(out_shares) !== 8'hA5) begin n_fail++; $display("FAIL first_x: got %h want a5", recomb(out_shares)); end
      idle(8);
   endtask

   task automatic test_zero_byte();
      next_cycle(1'b1, 24'h663C5A, 3'b000);
      next_cycle(1'b0, 24'h0, 3'b000);
      next_cycle(1'b0, 24'h0, 3'b000);
      next_cycle(1'b0, 24'h0, 3'b100);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_ov3: got %b want 0", out_valid); end
      next_cycle(1'b0, 24'h0, 3'b000);
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_ov4: got %b want 1", out_valid); end
      n_chk++; if (out_shares !== 24'h673C5A) begin n_fail++; $display("FAIL zero_os: got %h want 673c5a", out_shares); end
      n_chk++; if (in_flight !== 4'd1) begin n_fail++; $display("FAIL zero_if4: got %0d want 1", in_flight); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy); end
      repeat (3) next_cycle(1'b0, 24'h0, 3'b000);
      n_chk++; if (delta_dly_valid !== 1'b0) begin n_fail++; $display("FAIL zero_dv7: got %b want 0", delta_dly_valid); end
      next_cycle(1'b0, 24'h0, 3'b000);
      n_chk++; if (delta_dly_valid !== 1'b1) begin n_fail++; $display("FAIL zero_dv8: got %b want 1", delta_dly_valid); end
      n_chk++; if (delta_dly !== 3'b100) begin n_fail++; $display("FAIL zero_dd: got %b want 100", delta_dly); end
      next_cycle(1'b0, 24'h0, 3'b000);
      n_chk++; if (in_flight !== 4'd0) begin n_fail++; $display("FAIL zero_if9: got %0d want 0", in_flight); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got %b want 0", busy); end
      idle(2);
   endtask

   task automatic test_nonzero_byte();
      next_cycle(1'b1, 24'h563412, 3'b000);
      next_cycle(1'b0, 24'h0, 3'b111);
      next_cycle(1'b0, 24'h0, 3'b101);
      next_cycle(1'b0, 24'h0, 3'b011);
      next_cycle(1'b0, 24'h0, 3'b110);
      n_chk++; if (out_shares !== 24'h563513) begin n_fail++; $display("FAIL nz_os: got %h want 563513", out_shares); end
      n_chk++; if (recomb(out_shares) !== 8'h70) begin n_fail++; $display("FAIL nz_x: got %h want 70", recomb(out_shares)); end
      idle(10);
   endtask

   task automatic test_back_to_back();
      logic [7:0]  x [3];
      logic [23:0] s [3];
      logic [2:0]  dl [3];
      x[0] = 8'h00; x[1] = 8'h01; x[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         s[i]  = mk_shares(x[i]);
         dl[i] = mk_delta(x[i] == 8'h00);
      end
      for (int c = 0; c < 12; c++) begin
         next_cycle(c < 3, (c < 3) ? s[c] : 24'h0, (c >= 3 && c < 6) ? dl[c-3] : 3'($urandom));
         if (c >= 4 && c <= 6) begin
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ov c%0d: got %b want 1", c, out_valid); end
            n_chk++; if (recomb(out_shares) !== mapped(x[c-4])) begin n_fail++; $display("FAIL b2b_x c%0d: got %h want %h", c, recomb(out_shares), mapped(x[c-4])); end
         end
         if (c >= 8 && c <= 10) begin
            n_chk++; if (delta_dly !== dl[c-8] || delta_dly_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dd c%0d: got %b/%b want 1/%b", c, delta_dly_valid, delta_dly, dl[c-8]); end
         end
         if (c == 3) begin
            n_chk++; if (in_flight !== 4'd3) begin n_fail++; $display("FAIL b2b_if3: got %0d want 3", in_flight); end
         end
         if (c == 10) begin
            n_chk++; if (in_flight !== 4'd1) begin n_fail++; $display("FAIL b2b_if10: got %0d want 1", in_flight); end
         end
         if (c == 11) begin
            n_chk++; if (in_flight !== 4'd0) begin n_fail++; $display("FAIL b2b_if11: got %0d want 0", in_flight); end
         end
      end
   endtask

   task automatic test_bubbles();
      logic [7:0]  xa, xb;
      logic [23:0] sa, sb, ea;
      logic [2:0]  da, db;
      logic        pat [4];
      xa = 8'($urandom_range(255, 1)); xb = 8'h00;
      sa = mk_shares(xa); sb = mk_shares(xb);
      da = mk_delta(1'b0); db = mk_delta(1'b1);
      ea = apply_delta(sa, da);
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         next_cycle(c == 0 || c == 3, (c == 0) ? sa : ((c == 3) ? sb : 24'($urandom)),
                    (c == 3) ? da : ((c == 6) ? db : 3'($urandom)));
         if (c >= 4 && c <= 7) begin
            n_chk++; if (out_valid !== pat[c-4]) begin n_fail++; $display("FAIL bub_ov c%0d: got %b want %b", c, out_valid, pat[c-4]); end
         end
         if (c >= 4 && c <= 6) begin
            n_chk++; if (out_shares !== ea) begin n_fail++; $display("FAIL bub_os c%0d: got %h want %h", c, out_shares, ea); end
         end
         if (c == 7) begin
            n_chk++; if (recomb(out_shares) !== 8'h01) begin n_fail++; $display("FAIL bub_x: got %h want 01", recomb(out_shares)); end
         end
         if (c >= 8 && c <= 10) begin
            n_chk++; if (delta_dly !== da || delta_dly_valid !== (c == 8)) begin n_fail++; $display("FAIL bub_dd c%0d: got %b/%b want %b/%b", c, delta_dly_valid, delta_dly, c == 8, da); end
         end
         if (c == 11) begin
            n_chk++; if (delta_dly !== db || delta_dly_valid !== 1'b1) begin n_fail++; $display("FAIL bub_dd11: got %b/%b want 1/%b", delta_dly_valid, delta_dly, db); end
         end
      end
   endtask

   task automatic test_reset_mid();
      next_cycle(1'b1, mk_shares(8'h00), 3'b000);
      next_cycle(1'b1, mk_shares(8'h3C), 3'b000);
      next_cycle(1'b1, mk_shares(8'h77), 3'b000);
      rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0 || out_shares !== 24'h0) begin n_fail++; $display("FAIL mid_out: got %b/%h want 0/000000", out_valid, out_shares); end
      n_chk++; if (delta_dly_valid !== 1'b0 || delta_dly !== 3'b000) begin n_fail++; $display("FAIL mid_dd: got %b/%b want 0/000", delta_dly_valid, delta_dly); end
      n_chk++; if (in_flight !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_if: got %0d/%b want 0/0", in_flight, busy); end
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; shared_inp = 24'h0;
      for (int c = 0; c < 12; c++) begin
         next_cycle(1'b0, 24'h0, 3'($urandom));
         n_chk++; if (out_valid !== 1'b0 || delta_dly_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_after c%0d: got ov=%b dv=%b busy=%b want 0", c, out_valid, delta_dly_valid, busy);
         end
      end
   endtask

   task automatic test_random();
      logic [23:0] exp_sh;
      logic [2:0]  exp_dd;
      logic        ev_out, ev_dd, v;
      int          cnt;
      @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      exp_sh = '0; exp_dd = '0;
      for (int c = 0; c < NC; c++) begin
         @(negedge clk);
         ev_out = (c >= 4) && vh[c-4];
         if (ev_out) exp_sh = apply_delta(shh[c-4], dh[c-1]);
         ev_dd = (c >= 8) && vh[c-8];
         if (ev_dd) exp_dd = dh[c-5];
         cnt = 0;
         for (int t = c - 8; t < c; t++) if (t >= 0 && vh[t]) cnt++;
         n_chk++; if (out_valid !== ev_out) begin n_fail++; $display("FAIL rnd_ov c%0d: got %b want %b", c, out_valid, ev_out); end
         n_chk++; if (out_shares !== exp_sh) begin n_fail++; $display("FAIL rnd_os c%0d: got %h want %h", c, out_shares, exp_sh); end
         if (ev_out) begin
            n_chk++; if (recomb(out_shares) !== mapped(xh[c-4])) begin n_fail++; $display("FAIL rnd_x c%0d: got %h want %h", c, recomb(out_shares), mapped(xh[c-4])); end
         end
         n_chk++; if (delta_dly_valid !== ev_dd) begin n_fail++; $display("FAIL rnd_dv c%0d: got %b want %b", c, delta_dly_valid, ev_dd); end
         n_chk++; if (delta_dly !== exp_dd) begin n_fail++; $display("FAIL rnd_dd c%0d: got %b want %b", c, delta_dly, exp_dd); end
         if (ev_dd) begin
            n_chk++; if ((^delta_dly) !== (xh[c-8] == 8'h00)) begin n_fail++; $display("FAIL rnd_delta c%0d: got %b want %b", c, ^delta_dly, xh[c-8] == 8'h00); end
         end
         n_chk++; if (in_flight !== CNT_W'(cnt)) begin n_fail++; $display("FAIL rnd_if c%0d: got %0d want %0d", c, in_flight, cnt); end
         n_chk++; if (busy !== (cnt != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, cnt != 0); end
         v = (c < NC - 12) && ($urandom_range(3) != 0);
         vh[c]  = v;
         xh[c]  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         shh[c] = v ? mk_shares(xh[c]) : 24'($urandom);
         dh[c]  = (c >= 3 && vh[c-3]) ? mk_delta(xh[c-3] == 8'h00) : 3'($urandom);
         in_valid   = v;
         shared_inp = shh[c];
         delta_sh   = dh[c];
      end
   endtask

   initial begin
      test_reset();
      test_zero_byte();
      test_nonzero_byte();
      test_back_to_back();
      test_bubbles();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
